// File: rtl/sw_pe_array.sv
// Linear systolic Smith-Waterman scoring array: one PE per query base, subject streamed through,
// followed by a drain phase and a sequential scan of per-PE best scores into a valid/ready result.
module sw_pe_array #(
    parameter int N_PE    = 8,
    parameter int SCORE_W = 8,
    parameter int SPOS_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SCORE_W-1:0]         cfg_match,
    input  logic [SCORE_W-1:0]         cfg_mismatch,
    input  logic [SCORE_W-1:0]         cfg_gap,
    input  logic                       q_load,
    input  logic [3*N_PE-1:0]          q_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [1:0]                 s_data,
    input  logic                       s_last,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [SCORE_W-1:0]         res_score,
    output logic [$clog2(N_PE+1)-1:0]  res_qpos,
    output logic [SPOS_W-1:0]          res_spos,
    output logic                       busy
);
    localparam int QW = $clog2(N_PE + 1);
    localparam logic [SCORE_W-1:0] S_MAX = {SCORE_W{1'b1}};

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, SCAN, RESULT} state_t;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SCORE_W] ? S_MAX : s[SCORE_W-1:0];
    endfunction

    function automatic logic [SCORE_W-1:0] floor_sub(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    function automatic logic [SCORE_W-1:0] max2(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t                 state_q, state_d;
    logic [SPOS_W-1:0]      cnt_q, cnt_d;
    logic [QW-1:0]          cyc_q, cyc_d;
    logic [3*N_PE-1:0]      query_q, query_d;
    logic [SCORE_W-1:0]     res_score_q, res_score_d;
    logic [QW-1:0]          res_qpos_q, res_qpos_d;
    logic [SPOS_W-1:0]      res_spos_q, res_spos_d;

    logic                   accept;
    logic                   q_take;
    logic                   pe_clr;
    logic                   last_cyc;
    logic [SPOS_W-1:0]      pos_new;
    logic [SCORE_W-1:0]     sel_best;
    logic [SPOS_W-1:0]      sel_pos;

    logic                   val_arr  [N_PE];
    logic [1:0]             sym_arr  [N_PE];
    logic [SPOS_W-1:0]      pos_arr  [N_PE];
    logic [SCORE_W-1:0]     h_arr    [N_PE];
    logic [SCORE_W-1:0]     best_arr [N_PE];
    logic [SPOS_W-1:0]      bpos_arr [N_PE];

    // A reload is only legal before the first symbol of a sequence; cnt_q never returns to 0 once counting.
    assign accept   = s_valid && s_ready;
    assign q_take   = q_load && ((state_q == IDLE) || ((state_q == RUN) && (cnt_q == '0)));
    assign pe_clr   = q_take || ((state_q == RESULT) && res_ready);
    assign last_cyc = (cyc_q == QW'(N_PE - 1));
    assign pos_new  = (&cnt_q) ? cnt_q : cnt_q + SPOS_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (q_load) state_d = RUN;
            RUN:     if (accept && s_last) state_d = DRAIN;
            DRAIN:   if (last_cyc) state_d = SCAN;
            SCAN:    if (last_cyc) state_d = RESULT;
            RESULT:  if (res_ready) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready   = (state_q == RUN) && !q_load;
        res_valid = (state_q == RESULT);
        busy      = (state_q == DRAIN) || (state_q == SCAN) || (state_q == RESULT);
    end

    always_comb begin
        sel_best = '0;
        sel_pos  = '0;
        for (int i = 0; i < N_PE; i++) begin
            if (int'(cyc_q) == i) begin
                sel_best = best_arr[i];
                sel_pos  = bpos_arr[i];
            end
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        query_d     = query_q;
        cyc_d       = '0;
        res_score_d = res_score_q;
        res_qpos_d  = res_qpos_q;
        res_spos_d  = res_spos_q;
        if (pe_clr) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = pos_new;
        end
        if (q_take) begin
            query_d = q_data;
        end
        if ((state_q == DRAIN) || (state_q == SCAN)) begin
            cyc_d = last_cyc ? '0 : cyc_q + QW'(1);
        end
        // Running result starts from zero so a zero best reports position 0/0.
        if ((state_q == DRAIN) && last_cyc) begin
            res_score_d = '0;
            res_qpos_d  = '0;
            res_spos_d  = '0;
        end else if ((state_q == SCAN) && (sel_best > res_score_q)) begin
            res_score_d = sel_best;
            res_qpos_d  = cyc_q + QW'(1);
            res_spos_d  = sel_pos;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            cyc_q       <= '0;
            query_q     <= '0;
            res_score_q <= '0;
            res_qpos_q  <= '0;
            res_spos_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            query_q     <= query_d;
            res_score_q <= res_score_d;
            res_qpos_q  <= res_qpos_d;
            res_spos_q  <= res_spos_d;
        end
    end

    assign res_score = res_score_q;
    assign res_qpos  = res_qpos_q;
    assign res_spos  = res_spos_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_PE; gi++) begin : g_pe
            logic               in_val;
            logic [1:0]         in_sym;
            logic [SPOS_W-1:0]  in_pos;
            logic [SCORE_W-1:0] up;
            logic [2:0]         code;
            logic               val_q, val_d;
            logic [1:0]         sym_q, sym_d;
            logic [SPOS_W-1:0]  pos_q, pos_d;
            logic [SCORE_W-1:0] h_q, h_d;
            logic [SCORE_W-1:0] diag_q, diag_d;
            logic [SCORE_W-1:0] best_q, best_d;
            logic [SPOS_W-1:0]  bpos_q, bpos_d;
            logic [SCORE_W-1:0] diag_sub;
            logic [SCORE_W-1:0] h_new;

            if (gi == 0) begin : g_head
                assign in_val = accept;
                assign in_sym = s_data;
                assign in_pos = pos_new;
                assign up     = '0;
            end else begin : g_body
                assign in_val = val_arr[gi-1];
                assign in_sym = sym_arr[gi-1];
                assign in_pos = pos_arr[gi-1];
                assign up     = h_arr[gi-1];
            end

            assign code = query_q[3*gi +: 3];

            always_comb begin
                if (!code[2] && (code[1:0] == in_sym)) begin
                    diag_sub = sat_add(diag_q, cfg_match);
                end else begin
                    diag_sub = floor_sub(diag_q, cfg_mismatch);
                end
                h_new = max2(diag_sub, max2(floor_sub(up, cfg_gap), floor_sub(h_q, cfg_gap)));
            end

            // Bubbles shift a cleared valid but leave every score register untouched.
            always_comb begin
                val_d  = in_val && !pe_clr;
                sym_d  = sym_q;
                pos_d  = pos_q;
                h_d    = h_q;
                diag_d = diag_q;
                best_d = best_q;
                bpos_d = bpos_q;
                if (pe_clr) begin
                    sym_d  = '0;
                    pos_d  = '0;
                    h_d    = '0;
                    diag_d = '0;
                    best_d = '0;
                    bpos_d = '0;
                end else if (in_val) begin
                    sym_d  = in_sym;
                    pos_d  = in_pos;
                    h_d    = h_new;
                    diag_d = up;
                    if (h_new > best_q) begin
                        best_d = h_new;
                        bpos_d = in_pos;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    val_q  <= 1'b0;
                    sym_q  <= '0;
                    pos_q  <= '0;
                    h_q    <= '0;
                    diag_q <= '0;
                    best_q <= '0;
                    bpos_q <= '0;
                end else begin
                    val_q  <= val_d;
                    sym_q  <= sym_d;
                    pos_q  <= pos_d;
                    h_q    <= h_d;
                    diag_q <= diag_d;
                    best_q <= best_d;
                    bpos_q <= bpos_d;
                end
            end

            assign val_arr[gi]  = val_q;
            assign sym_arr[gi]  = sym_q;
            assign pos_arr[gi]  = pos_q;
            assign h_arr[gi]    = h_q;
            assign best_arr[gi] = best_q;
            assign bpos_arr[gi] = bpos_q;
        end
    endgenerate

endmodule

// File: tb/tb_sw_pe_array.sv
// Randomised and directed bench for sw_pe_array against a full dynamic-programming matrix model.
module tb_sw_pe_array;
    localparam int N    = 4;
    localparam int SW   = 8;
    localparam int PW   = 16;
    localparam int QW   = $clog2(N + 1);
    localparam int MAXL = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [SW-1:0]   cfg_match, cfg_mismatch, cfg_gap;
    logic            q_load;
    logic [3*N-1:0]  q_data;
    logic            s_valid;
    logic            s_ready;
    logic [1:0]      s_data;
    logic            s_last;
    logic            res_valid;
    logic            res_ready;
    logic [SW-1:0]   res_score;
    logic [QW-1:0]   res_qpos;
    logic [PW-1:0]   res_spos;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    sw_pe_array #(.N_PE(N), .SCORE_W(SW), .SPOS_W(PW)) dut (
        .clk(clk), .rst(rst),
        .cfg_match(cfg_match), .cfg_mismatch(cfg_mismatch), .cfg_gap(cfg_gap),
        .q_load(q_load), .q_data(q_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_score(res_score), .res_qpos(res_qpos), .res_spos(res_spos),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full local-alignment matrix; scanning query-major then subject keeps the lowest (i, j) on ties.
    task automatic model(input int q[N], input int s[$], input int m, input int mm, input int g,
                         output int bs, output int bq, output int bp);
        int h [N+1][MAXL+1];
        int smax, d, u, l, v;
        smax = (1 << SW) - 1;
        for (int i = 0; i <= N; i++)
            for (int j = 0; j <= MAXL; j++)
                h[i][j] = 0;
        for (int i = 1; i <= N; i++) begin
            for (int j = 1; j <= s.size(); j++) begin
                if (q[i-1] < 4 && q[i-1] == s[j-1]) d = h[i-1][j-1] + m;
                else                                d = h[i-1][j-1] - mm;
                if (d > smax) d = smax;
                u = h[i-1][j] - g;
                l = h[i][j-1] - g;
                v = 0;
                if (d > v) v = d;
                if (u > v) v = u;
                if (l > v) v = l;
                h[i][j] = v;
            end
        end
        bs = 0; bq = 0; bp = 0;
        for (int i = 1; i <= N; i++)
            for (int j = 1; j <= s.size(); j++)
                if (h[i][j] > bs) begin
                    bs = h[i][j]; bq = i; bp = j;
                end
    endtask

    task automatic load_query(input int q[N]);
        for (int i = 0; i < N; i++) q_data[3*i +: 3] = 3'(q[i]);
        q_load = 1'b1;
        #1;
        chk("s_ready_during_load", {31'd0, s_ready}, 0);
        step();
        q_load = 1'b0;
        #1;
        chk("s_ready_after_load", {31'd0, s_ready}, 1);
    endtask

    task automatic run_seq(input string tag, input int s[$], input int es, input int eq, input int ep,
                           input bit bub, input int hold, input bit reload);
        int lat;
        for (int j = 0; j < s.size(); j++) begin
            if (bub) repeat ($urandom_range(0, 2)) step();
            if (reload && j == 1) begin
                q_load = 1'b1;
                q_data = 12'($urandom);
                #1;
                chk("s_ready_ignored_load", {31'd0, s_ready}, 0);
                step();
                q_load = 1'b0;
            end
            s_valid = 1'b1;
            s_data  = 2'(s[j]);
            s_last  = (j == s.size() - 1);
            #1;
            chk("s_ready_run", {31'd0, s_ready}, 1);
            step();
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
        lat = 0;
        for (int k = 1; k <= 64; k++) begin
            if (res_valid) break;
            chk("s_ready_busy", {31'd0, s_ready}, 0);
            step();
            if (res_valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, 2 * N);
        for (int c = 0; c < hold; c++) begin
            chk("hold_valid", {31'd0, res_valid}, 1);
            chk("hold_score", {24'd0, res_score}, es);
            chk("hold_sready", {31'd0, s_ready}, 0);
            step();
        end
        chk("res_valid", {31'd0, res_valid}, 1);
        chk("res_score", {24'd0, res_score}, es);
        chk("res_qpos", {29'd0, res_qpos}, eq);
        chk("res_spos", {16'd0, res_spos}, ep);
        chk("busy_result", {31'd0, busy}, 1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("valid_after_hs", {31'd0, res_valid}, 0);
        chk("busy_after_hs", {31'd0, busy}, 0);
        $display("seq %s len=%0d score=%0d qpos=%0d spos=%0d exp=%0d/%0d/%0d",
                 tag, s.size(), res_score, res_qpos, res_spos, es, eq, ep);
    endtask

    initial begin
        int q[N];
        int s[$];
        int es, eq, ep, len;

        rst = 1'b1; q_load = 0; q_data = 0; s_valid = 0; s_data = 0; s_last = 0; res_ready = 0;
        cfg_match = 8'd2; cfg_mismatch = 8'd1; cfg_gap = 8'd1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sready", {31'd0, s_ready}, 0);
        chk("rst_valid", {31'd0, res_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_score", {24'd0, res_score}, 0);
        chk("rst_qpos", {29'd0, res_qpos}, 0);
        chk("rst_spos", {16'd0, res_spos}, 0);
        rst = 1'b0;
        step();
        chk("idle_sready", {31'd0, s_ready}, 0);

        q = '{0, 1, 2, 3};
        load_query(q);
        s = '{0, 1, 2, 3};
        run_seq("acgt", s, 8, 4, 4, 1'b0, 0, 1'b0);
        run_seq("acgt_bub", s, 8, 4, 4, 1'b1, 5, 1'b1);

        q = '{0, 0, 0, 0};
        load_query(q);
        s = '{3, 3, 3};
        run_seq("aaaa_ttt", s, 0, 0, 0, 1'b0, 1, 1'b0);

        q = '{4, 4, 4, 4};
        load_query(q);
        s = '{0, 0};
        run_seq("wild", s, 0, 0, 0, 1'b0, 0, 1'b0);
        cfg_match = 8'd255;
        q = '{1, 1, 1, 1};
        load_query(q);
        s = '{1, 1};
        run_seq("sat", s, 255, 1, 1, 1'b0, 0, 1'b0);

        cfg_match = 8'd2;
        q = '{2, 0, 2, 0};
        load_query(q);
        s = '{2, 0, 2, 0, 2, 0};
        run_seq("gaga1", s, 8, 4, 4, 1'b0, 0, 1'b0);
        run_seq("gaga2", s, 8, 4, 4, 1'b1, 2, 1'b0);

        for (int it = 0; it < 20; it++) begin
            cfg_match    = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(1, 6));
            cfg_mismatch = 8'($urandom_range(0, 4));
            cfg_gap      = 8'($urandom_range(0, 4));
            for (int i = 0; i < N; i++) q[i] = $urandom_range(0, 7);
            load_query(q);
            len = (it == 0) ? 1 : $urandom_range(1, 12);
            s.delete();
            for (int j = 0; j < len; j++) s.push_back($urandom_range(0, 3));
            model(q, s, int'(cfg_match), int'(cfg_mismatch), int'(cfg_gap), es, eq, ep);
            run_seq("rand", s, es, eq, ep, 1'b1, $urandom_range(0, 3), it[0]);
        end

        cfg_match = 8'd2; cfg_mismatch = 8'd1; cfg_gap = 8'd1;
        q = '{0, 1, 2, 3};
        load_query(q);
        for (int j = 0; j < 2; j++) begin
            s_valid = 1'b1;
            s_data  = 2'(j);
            step();
        end
        s_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_sready", {31'd0, s_ready}, 0);
        chk("arst_valid", {31'd0, res_valid}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_score", {24'd0, res_score}, 0);
        #1;
        rst = 1'b0;
        repeat (3) step();
        chk("arst_idle_sready", {31'd0, s_ready}, 0);
        load_query(q);
        s = '{0, 1, 2, 3};
        run_seq("after_rst", s, 8, 4, 4, 1'b0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
